// File: rtl/s2m_burst_writer.sv
// s2m_burst_writer
//   Stream-to-memory writer. Each wide sink beat is split into RATIO master
//   beats (least-significant slice first), buffered in a small FIFO, and
//   written out as fixed-length Avalon-MM bursts of BURST beats starting at a
//   CSR-programmed byte address.
//
// Ports
//   clock, reset_n            : clock, asynchronous active-low reset
//   csr_write/read/address    : CSR access (word index 0..7)
//   csr_writedata/readdata    : CSR data, read data has 1-cycle latency
//   m_write/address/writedata : master write burst request
//   m_burstcount              : constant BURST
//   m_waitrequest             : slave stall
//   snk_data/valid/ready      : wide Avalon-ST sink, ready is registered
//   irq                       : STATUS.done AND CTRL.irq_en
//
// CSR map: 0 LENGTH, 1 ADDR, 2 CTRL{abort,irq_en,start}, 3 STATUS{aborted,
//   error,done,busy}, 4 REMAIN, 5..7 read as zero.
module s2m_burst_writer #(
  parameter int MASTER_W   = 256,
  parameter int RATIO      = 2,
  parameter int BURST      = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      csr_write,
  input  logic                      csr_read,
  input  logic [2:0]                csr_address,
  input  logic [31:0]               csr_writedata,
  output logic [31:0]               csr_readdata,
  output logic                      m_write,
  output logic [ADDR_W-1:0]         m_address,
  output logic [MASTER_W-1:0]       m_writedata,
  output logic [$clog2(BURST):0]    m_burstcount,
  input  logic                      m_waitrequest,
  input  logic [MASTER_W*RATIO-1:0] snk_data,
  input  logic                      snk_valid,
  output logic                      snk_ready,
  output logic                      irq
);

  localparam int BYTES = MASTER_W / 8;
  // Pointer width is kept >= 1 so a single-entry FIFO still elaborates; the
  // occupancy count, not the pointer range, bounds the capacity.
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int BCW   = $clog2(BURST) + 1;

  localparam logic [CW-1:0]     DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]     RATIO_C   = CW'(RATIO);
  localparam logic [CW-1:0]     BURST_C   = CW'(BURST);
  localparam logic [BCW-1:0]    LAST_BEAT = BCW'(BURST - 1);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BURST * BYTES);
  localparam logic [31:0]       BURST_M   = 32'(BURST - 1);
  localparam logic [31:0]       RATIO_M   = 32'(RATIO - 1);
  localparam logic [31:0]       BYTES_M   = 32'(BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DRAIN} state_e;

  // ---------------------------------------------------------------- state
  state_e               state_q, state_d;
  logic [31:0]          length_q, length_d;
  logic [31:0]          addr_csr_q, addr_csr_d;
  logic                 irq_en_q, irq_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 aborted_q, aborted_d;
  logic                 abort_q, abort_d;
  logic [31:0]          remain_q, remain_d;
  logic [31:0]          sink_rem_q, sink_rem_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BCW-1:0]       beat_q, beat_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_step;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 snk_ready_q, snk_ready_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [MASTER_W-1:0]  mem_q [2**PW];

  // ---------------------------------------------------------------- decode
  logic wr_len, wr_addr, wr_ctrl, wr_stat;
  logic start_cmd, abort_cmd, start_bad, start_ok, start_err, abort_pend;
  logic push, pop, drain, set_done, set_abort;

  assign wr_len    = csr_write && (csr_address == 3'd0);
  assign wr_addr   = csr_write && (csr_address == 3'd1);
  assign wr_ctrl   = csr_write && (csr_address == 3'd2);
  assign wr_stat   = csr_write && (csr_address == 3'd3);

  // Abort in the same write as start suppresses the start.
  assign abort_cmd = wr_ctrl && csr_writedata[2];
  assign start_cmd = wr_ctrl && csr_writedata[0] && !csr_writedata[2];

  assign start_bad = (length_q == 32'd0) || (|(length_q & BURST_M)) ||
                     (|(length_q & RATIO_M)) || (|(addr_csr_q & BYTES_M));
  assign start_ok  = start_cmd && !busy_q && !start_bad;
  assign start_err = start_cmd && !busy_q && start_bad;

  // A fresh abort request is acted on in the same cycle it is written.
  assign abort_pend = abort_q || (abort_cmd && busy_q);

  assign m_write = (state_q == S_BURST);
  assign push    = snk_valid && snk_ready_q;
  assign pop     = m_write && !m_waitrequest;

  // FIFO occupancy after this cycle's push/pop, before any drain flush.
  assign cnt_step = cnt_q + (push ? RATIO_C : '0) - (pop ? CW'(1) : '0);

  // ---------------------------------------------------------------- master FSM
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    drain     = 1'b0;
    set_done  = 1'b0;
    set_abort = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_WAIT;
          addr_d  = addr_csr_q[ADDR_W-1:0];
        end
      end
      S_WAIT: begin
        if (abort_pend) begin
          state_d = S_DRAIN;
        end else if (cnt_q >= BURST_C) begin
          state_d = S_BURST;
          beat_d  = '0;
        end
      end
      S_BURST: begin
        if (pop) begin
          beat_d = beat_q + BCW'(1);
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            addr_d = addr_q + STEP;
            if (remain_q == 32'd1) begin
              state_d  = S_IDLE;
              set_done = 1'b1;
            end else if (abort_pend) begin
              state_d = S_DRAIN;
            end else if (cnt_step >= BURST_C) begin
              // Enough data already buffered: chain straight into next burst.
              state_d = S_BURST;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      S_DRAIN: begin
        drain     = 1'b1;
        set_abort = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath next-state
  always_comb begin
    cnt_d    = drain ? '0 : cnt_step;
    wr_ptr_d = drain ? '0 : wr_ptr_q + (push ? PW'(RATIO) : '0);
    rd_ptr_d = drain ? '0 : rd_ptr_q + PW'(pop);

    remain_d = remain_q;
    if (start_ok)  remain_d = length_q;
    else if (pop)  remain_d = remain_q - 32'd1;

    sink_rem_d = sink_rem_q;
    if (start_ok)  sink_rem_d = length_q / 32'(RATIO);
    else if (push) sink_rem_d = sink_rem_q - 32'd1;

    length_d   = (wr_len  && !busy_q) ? csr_writedata : length_q;
    addr_csr_d = (wr_addr && !busy_q) ? csr_writedata : addr_csr_q;
    irq_en_d   = wr_ctrl ? csr_writedata[1] : irq_en_q;

    busy_d = busy_q;
    if (start_ok)                    busy_d = 1'b1;
    else if (set_done || set_abort)  busy_d = 1'b0;

    // Hardware set wins over a simultaneous write-1-to-clear.
    done_d = done_q;
    if (wr_stat && csr_writedata[1]) done_d = 1'b0;
    if (start_ok)                    done_d = 1'b0;
    if (set_done)                    done_d = 1'b1;

    error_d = error_q;
    if (wr_stat && csr_writedata[2]) error_d = 1'b0;
    if (start_err)                   error_d = 1'b1;

    aborted_d = aborted_q;
    if (wr_stat && csr_writedata[3]) aborted_d = 1'b0;
    if (start_ok)                    aborted_d = 1'b0;
    if (set_abort)                   aborted_d = 1'b1;

    abort_d = abort_pend;
    if (set_done || set_abort) abort_d = 1'b0;

    snk_ready_d = busy_d && !abort_d && (sink_rem_d != 32'd0) &&
                  (cnt_d <= (DEPTH_C - RATIO_C));

    rdata_d = rdata_q;
    if (csr_read) begin
      case (csr_address)
        3'd0:    rdata_d = length_q;
        3'd1:    rdata_d = addr_csr_q;
        3'd2:    rdata_d = {30'd0, irq_en_q, 1'b0};
        3'd3:    rdata_d = {28'd0, aborted_q, error_q, done_q, busy_q};
        3'd4:    rdata_d = remain_q;
        default: rdata_d = 32'd0;
      endcase
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      length_q    <= '0;
      addr_csr_q  <= '0;
      irq_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      aborted_q   <= 1'b0;
      abort_q     <= 1'b0;
      remain_q    <= '0;
      sink_rem_q  <= '0;
      addr_q      <= '0;
      beat_q      <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      snk_ready_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      length_q    <= length_d;
      addr_csr_q  <= addr_csr_d;
      irq_en_q    <= irq_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      aborted_q   <= aborted_d;
      abort_q     <= abort_d;
      remain_q    <= remain_d;
      sink_rem_q  <= sink_rem_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      snk_ready_q <= snk_ready_d;
      rdata_q     <= rdata_d;
    end
  end

  // FIFO storage carries no control meaning, so it is left unreset.
  always_ff @(posedge clock) begin
    if (push) begin
      for (int i = 0; i < RATIO; i++) begin
        mem_q[wr_ptr_q + PW'(i)] <= snk_data[i*MASTER_W +: MASTER_W];
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign m_address    = addr_q;
  assign m_writedata  = m_write ? mem_q[rd_ptr_q] : '0;
  assign m_burstcount = BCW'(BURST);
  assign snk_ready    = snk_ready_q;
  assign csr_readdata = rdata_q;
  assign irq          = done_q && irq_en_q;

endmodule

// File: tb/tb_s2m_burst_writer.sv
module tb_s2m_burst_writer;
  localparam int MW    = 256;
  localparam int R     = 2;
  localparam int B     = 2;
  localparam int FD    = 8;
  localparam int AW    = 32;
  localparam int SW    = MW * R;
  localparam int BYTES = MW / 8;

  typedef struct packed {
    logic [31:0]   addr;
    logic [MW-1:0] data;
  } beat_t;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic                   csr_write, csr_read;
  logic [2:0]             csr_address;
  logic [31:0]            csr_writedata, csr_readdata;
  logic                   m_write;
  logic [AW-1:0]          m_address;
  logic [MW-1:0]          m_writedata;
  logic [$clog2(B):0]     m_burstcount;
  logic                   m_waitrequest;
  logic [SW-1:0]          snk_data;
  logic                   snk_valid, snk_ready, irq;

  int          checks = 0;
  int          failures = 0;
  beat_t       exp_q[$];
  int          acc_cnt = 0;
  int          mbeat = 0;
  int          exp_limit = 0;
  logic [31:0] exp_base = '0;
  bit          rand_wait_en = 1'b0;
  logic        wait_force = 1'b0;

  s2m_burst_writer #(
    .MASTER_W(MW), .RATIO(R), .BURST(B), .FIFO_DEPTH(FD), .ADDR_W(AW)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .csr_write(csr_write), .csr_read(csr_read), .csr_address(csr_address),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .m_write(m_write), .m_address(m_address), .m_writedata(m_writedata),
    .m_burstcount(m_burstcount), .m_waitrequest(m_waitrequest),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .irq(irq)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Slave stall generator: random 50% or a value forced by the main sequence.
  always @(posedge clock) begin
    #2;
    m_waitrequest = rand_wait_en ? 1'($urandom % 2) : wait_force;
  end

  // ---------------------------------------------------------------- monitor
  int          bib = 0;
  logic [31:0] burst_base = '0;
  always @(negedge clock) begin
    beat_t e;
    if (!reset_n) begin
      bib = 0;
    end else begin
      if (bib != 0) begin
        checks++;
        if (!m_write || m_address !== burst_base) begin
          failures++;
          $display("FAIL burst_hold m_write=%0b addr=%0h required m_write=1 addr=%0h",
                   m_write, m_address, burst_base);
        end
      end
      if (m_write && !m_waitrequest) begin
        if (bib == 0) burst_base = m_address;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat addr=%0h data=%0h", m_address, m_writedata);
        end else begin
          e = exp_q.pop_front();
          if (e.addr !== m_address || e.data !== m_writedata ||
              m_burstcount !== ($clog2(B)+1)'(B)) begin
            failures++;
            $display("FAIL beat addr=%0h data=%0h bc=%0d required addr=%0h data=%0h bc=%0d",
                     m_address, m_writedata, m_burstcount, e.addr, e.data, B);
          end
        end
        acc_cnt++;
        bib = (bib + 1) % B;
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    csr_write = 1'b1; csr_address = a; csr_writedata = d;
    @(posedge clock); #1;
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    csr_read = 1'b1; csr_address = a;
    @(posedge clock); #1;
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  // Reference model: master beat j of the transfer carries slice (j % R) of
  // sink beat j / R and targets the base of burst j / B.
  task automatic model_push(input logic [SW-1:0] d);
    beat_t e;
    for (int s = 0; s < R; s++) begin
      if (mbeat < exp_limit) begin
        e.addr = exp_base + 32'((mbeat / B) * B * BYTES);
        e.data = d[s*MW +: MW];
        exp_q.push_back(e);
      end
      mbeat++;
    end
  endtask

  task automatic send_beat(input logic [SW-1:0] d);
    int n = 0;
    snk_valid = 1'b1; snk_data = d;
    @(negedge clock);
    while (!snk_ready && n < 500) begin n++; @(negedge clock); end
    checks++;
    if (!snk_ready) begin
      failures++;
      $display("FAIL sink_accept timeout waiting for snk_ready");
    end
    @(posedge clock); #1;
    snk_valid = 1'b0;
  endtask

  task automatic rand_wide(output logic [SW-1:0] d);
    for (int i = 0; i < SW/32; i++) d[i*32 +: 32] = $urandom;
  endtask

  task automatic wait_idle(output logic [31:0] st);
    int n = 0;
    csr_rd(3'd3, st);
    while (st[0] && n < 3000) begin n++; csr_rd(3'd3, st); end
    checks++;
    if (st[0]) begin
      failures++;
      $display("FAIL busy_timeout status=%0h required busy=0", st);
    end
  endtask

  task automatic begin_xfer(input logic [31:0] base, input int len, input int limit);
    csr_wr(3'd1, base);
    csr_wr(3'd0, 32'(len));
    exp_base = base; mbeat = 0; exp_limit = limit;
    csr_wr(3'd2, 32'h3);
  endtask

  task automatic run_xfer(input logic [31:0] base, input int len, input bit rw, input bit gaps);
    logic [31:0]   r;
    logic [SW-1:0] d;
    rand_wait_en = rw;
    begin_xfer(base, len, len);
    csr_wr(3'd0, 32'd2);
    csr_rd(3'd0, r);
    chk("length_locked_while_busy", 64'(r), 64'(len));
    for (int k = 0; k < len / R; k++) begin
      rand_wide(d);
      model_push(d);
      send_beat(d);
      if (gaps) repeat ($urandom % 3) begin @(posedge clock); #1; end
    end
    wait_idle(r);
    rand_wait_en = 1'b0;
    chk("status_done", 64'(r), 64'h2);
    csr_rd(3'd4, r);
    chk("remain_zero", 64'(r), 64'h0);
    chk("irq_on_done", 64'(irq), 64'h1);
    chk("all_beats_written", 64'(exp_q.size()), 64'h0);
    csr_wr(3'd3, 32'h2);
    chk("irq_after_clear", 64'(irq), 64'h0);
    csr_rd(3'd3, r);
    chk("status_cleared", 64'(r), 64'h0);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    logic [31:0]   r;
    logic [SW-1:0] d;
    logic [31:0]   bad_addr [2];
    int            bad_len  [2];
    int            n;

    reset_n = 1'b1; csr_write = 0; csr_read = 0; csr_address = '0;
    csr_writedata = '0; snk_valid = 0; snk_data = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_m_write", 64'(m_write), 64'h0);
    chk("rst_snk_ready", 64'(snk_ready), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_csr_readdata", 64'(csr_readdata), 64'h0);
    chk("rst_m_address", 64'(m_address), 64'h0);
    chk("rst_m_writedata", 64'(m_writedata == '0), 64'h1);
    reset_n = 1'b1;
    @(posedge clock); #1;
    for (int a = 0; a < 8; a++) begin
      csr_rd(3'(a), r);
      chk($sformatf("rst_csr%0d", a), 64'(r), 64'h0);
    end

    // Basic transfer, then the same shape under random stalls and gaps.
    run_xfer(32'h1000, 8, 1'b0, 1'b0);
    run_xfer(32'h1000, 16, 1'b1, 1'b1);

    // Illegal starts: misaligned address, then length not a burst multiple.
    bad_addr[0] = 32'h1004; bad_len[0] = 6;
    bad_addr[1] = 32'h1000; bad_len[1] = 3;
    for (int i = 0; i < 2; i++) begin
      begin_xfer(bad_addr[i], bad_len[i], 0);
      repeat (4) @(posedge clock);
      #1;
      csr_rd(3'd3, r);
      chk($sformatf("error_start%0d", i), 64'(r), 64'h4);
      chk($sformatf("error_no_ready%0d", i), 64'(snk_ready), 64'h0);
      csr_wr(3'd3, 32'h4);
      csr_rd(3'd3, r);
      chk($sformatf("error_cleared%0d", i), 64'(r), 64'h0);
    end

    // Abort after the first beat of burst 2: burst 2 finishes, rest dropped.
    wait_force = 1'b1;
    begin_xfer(32'h2000, 16, 4);
    for (int k = 0; k < 4; k++) begin
      rand_wide(d); model_push(d); send_beat(d);
    end
    acc_cnt = 0;
    wait_force = 1'b0;
    n = 0;
    while (acc_cnt < 3 && n < 200) begin @(negedge clock); #1; n++; end
    chk("abort_sync_beats", 64'(acc_cnt), 64'h3);
    @(posedge clock); #1;
    wait_force = 1'b1;
    csr_wr(3'd2, 32'h6);
    wait_force = 1'b0;
    wait_idle(r);
    chk("abort_status", 64'(r), 64'h8);
    csr_rd(3'd4, r);
    chk("abort_remain", 64'(r), 64'd12);
    chk("abort_irq", 64'(irq), 64'h0);
    chk("abort_queue", 64'(exp_q.size()), 64'h0);
    repeat (5) @(posedge clock);
    #1;
    chk("abort_no_ready", 64'(snk_ready), 64'h0);
    csr_wr(3'd3, 32'h8);

    // Reset asserted while a burst is stalled on the bus.
    wait_force = 1'b1;
    begin_xfer(32'h3000, 8, 0);
    for (int k = 0; k < 2; k++) begin
      rand_wide(d); model_push(d); send_beat(d);
    end
    csr_rd(3'd1, r);
    chk("pre_reset_addr", 64'(r), 64'h3000);
    n = 0;
    @(negedge clock);
    while (!m_write && n < 50) begin n++; @(negedge clock); end
    chk("pre_reset_m_write", 64'(m_write), 64'h1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_m_write", 64'(m_write), 64'h0);
    chk("mid_rst_m_address", 64'(m_address), 64'h0);
    chk("mid_rst_m_writedata", 64'(m_writedata == '0), 64'h1);
    chk("mid_rst_csr_readdata", 64'(csr_readdata), 64'h0);
    chk("mid_rst_snk_ready", 64'(snk_ready), 64'h0);
    exp_q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    wait_force = 1'b0;
    for (int a = 0; a < 5; a++) begin
      csr_rd(3'(a), r);
      chk($sformatf("post_rst_csr%0d", a), 64'(r), 64'h0);
    end

    // Address wraps modulo 2^32 across the burst sequence.
    run_xfer(32'hFFFF_FFC0, 8, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
